// File: rtl/reg_writeback_queue.sv
// reg_writeback_queue
//   Write-side front end for the 4x8-bit register file. ALU and load results
//   arrive over valid/ready. They are buffered in an in-order FIFO and drained
//   at one write per cycle onto the register file's registered write port. A
//   per-register pending counter drives busy_mask so that decode can stall on
//   RAW hazards.
//
// Ports
//   clk, reset                         clock; synchronous active-high reset
//   alu_valid/alu_ready/alu_reg/alu_value   ALU result channel (lower priority)
//   mem_valid/mem_ready/mem_reg/mem_value   load result channel (higher priority)
//   write_en/write_reg/write_value     registered register-file write port
//   busy_mask                          bit i set while a write to reg i is pending
//   idle                               FIFO empty and no write on the port
module reg_writeback_queue #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       alu_valid,
    output logic       alu_ready,
    input  logic [1:0] alu_reg,
    input  logic [7:0] alu_value,
    input  logic       mem_valid,
    output logic       mem_ready,
    input  logic [1:0] mem_reg,
    input  logic [7:0] mem_value,
    output logic       write_en,
    output logic [1:0] write_reg,
    output logic [7:0] write_value,
    output logic [3:0] busy_mask,
    output logic       idle
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    // Pending counters must reach DEPTH+1: a full FIFO plus the output register.
    localparam int SW = $clog2(DEPTH + 2);

    logic [1:0]    fifo_reg   [DEPTH];
    logic [7:0]    fifo_value [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [SW-1:0] pend [4];

    logic       full;
    logic       push;
    logic       pop;
    logic [1:0] push_reg;
    logic [7:0] push_value;

    // Ready depends only on registered state and mem_valid, never on alu_valid,
    // so upstream valid/ready loops cannot form.
    assign full      = (count == CW'(DEPTH));
    assign mem_ready = !full;
    assign alu_ready = !full && !mem_valid;

    assign push       = (mem_valid && mem_ready) || (alu_valid && alu_ready);
    assign push_reg   = mem_valid ? mem_reg   : alu_reg;
    assign push_value = mem_valid ? mem_value : alu_value;
    assign pop        = (count != '0);

    assign idle = (count == '0) && !write_en;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_reg[wr_ptr]   <= push_reg;
            fifo_value[wr_ptr] <= push_value;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            write_en    <= 1'b0;
            write_reg   <= '0;
            write_value <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr      <= rd_ptr + PW'(1);
                write_en    <= 1'b1;
                write_reg   <= fifo_reg[rd_ptr];
                write_value <= fifo_value[rd_ptr];
            end else begin
                write_en <= 1'b0;
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // A write stays pending until the edge at which the register file commits it,
    // i.e. the edge where it is presented with write_en high.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (reset) begin
                pend[i] <= '0;
            end else begin
                if ((push && push_reg == 2'(i)) && !(write_en && write_reg == 2'(i))) begin
                    pend[i] <= pend[i] + SW'(1);
                end else if (!(push && push_reg == 2'(i)) && (write_en && write_reg == 2'(i))) begin
                    pend[i] <= pend[i] - SW'(1);
                end
            end
        end
    end

    always_comb begin
        busy_mask = '0;
        for (int i = 0; i < 4; i++) begin
            busy_mask[i] = (pend[i] != '0);
        end
    end

endmodule

// File: tb/tb_reg_writeback_queue.sv
module tb_reg_writeback_queue;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       alu_valid, mem_valid;
    logic       alu_ready, mem_ready;
    logic [1:0] alu_reg, mem_reg;
    logic [7:0] alu_value, mem_value;
    logic       write_en;
    logic [1:0] write_reg;
    logic [7:0] write_value;
    logic [3:0] busy_mask;
    logic       idle;

    int checks = 0;
    int errors = 0;

    // Expected writes in acceptance order: {reg, value}
    logic [9:0] sb [$];
    logic [7:0] regfile [4];
    bit         mon_en = 1'b0;

    reg_writeback_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_reg(alu_reg), .alu_value(alu_value),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_reg(mem_reg), .mem_value(mem_value),
        .write_en(write_en), .write_reg(write_reg), .write_value(write_value),
        .busy_mask(busy_mask), .idle(idle)
    );

    always #5 clk = ~clk;

    // Record accepted results at the edge they are taken.
    always @(posedge clk) begin
        if (reset) begin
            sb.delete();
        end else if (mem_valid && mem_ready) begin
            sb.push_back({mem_reg, mem_value});
        end else if (alu_valid && alu_ready) begin
            sb.push_back({alu_reg, alu_value});
        end
    end

    // Check busy_mask against the outstanding set, then retire writes seen on the port.
    always @(negedge clk) begin
        if (mon_en && !reset) begin
            logic [3:0] exp_mask;
            logic [9:0] head;
            exp_mask = '0;
            foreach (sb[i]) exp_mask[sb[i][9:8]] = 1'b1;
            checks++;
            if (busy_mask !== exp_mask) begin
                errors++;
                $display("FAIL busy_mask_model got %b expected %b at %0t", busy_mask, exp_mask, $time);
            end
            if (write_en === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL spurious_write got reg %0d val %h expected no write at %0t",
                             write_reg, write_value, $time);
                end else begin
                    head = sb.pop_front();
                    if ({write_reg, write_value} !== head) begin
                        errors++;
                        $display("FAIL write_order got reg %0d val %h expected reg %0d val %h",
                                 write_reg, write_value, head[9:8], head[7:0]);
                    end
                    regfile[write_reg] = write_value;
                end
            end
        end
    end

    task automatic idle_inputs();
        alu_valid = 0; mem_valid = 0;
        alu_reg = 0; mem_reg = 0; alu_value = 0; mem_value = 0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (!(idle === 1'b1 && sb.size() == 0) && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 50) begin
            errors++;
            $display("FAIL %s_drain got idle %b pending %0d expected idle 1 pending 0", name, idle, sb.size());
        end
    endtask

    task automatic test_reset();
        reset = 1; idle_inputs();
        repeat (2) @(negedge clk);
        checks++;
        if ({write_en, write_reg, write_value, busy_mask, idle, alu_ready, mem_ready} !== {1'b0, 2'd0, 8'd0, 4'd0, 1'b1, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL reset_state got we %b reg %0d val %h busy %b idle %b ar %b mr %b expected 0 0 00 0000 1 1 1",
                     write_en, write_reg, write_value, busy_mask, idle, alu_ready, mem_ready);
        end
        reset = 0;
        mon_en = 1;
    endtask

    task automatic test_single_latency();
        alu_valid = 1; alu_reg = 2; alu_value = 8'h5A;
        #1;
        checks++;
        if (alu_ready !== 1'b1) begin
            errors++; $display("FAIL single_ready got %b expected 1", alu_ready);
        end
        @(negedge clk);   // accepted at edge k
        alu_valid = 0;
        checks++;
        if (write_en !== 1'b0 || busy_mask !== 4'b0100) begin
            errors++; $display("FAIL single_k got we %b busy %b expected 0 0100", write_en, busy_mask);
        end
        @(negedge clk);   // after edge k+1
        checks++;
        if ({write_en, write_reg, write_value} !== {1'b1, 2'd2, 8'h5A} || busy_mask !== 4'b0100) begin
            errors++; $display("FAIL single_k1 got we %b reg %0d val %h busy %b expected 1 2 5a 0100",
                               write_en, write_reg, write_value, busy_mask);
        end
        @(negedge clk);   // after commit edge k+2
        checks++;
        if (write_en !== 1'b0 || busy_mask !== 4'b0000 || idle !== 1'b1) begin
            errors++; $display("FAIL single_k2 got we %b busy %b idle %b expected 0 0000 1", write_en, busy_mask, idle);
        end
        wait_idle("single");
    endtask

    task automatic test_priority();
        mem_valid = 1; mem_reg = 1; mem_value = 8'h11;
        alu_valid = 1; alu_reg = 3; alu_value = 8'h22;
        #1;
        checks++;
        if (mem_ready !== 1'b1 || alu_ready !== 1'b0) begin
            errors++; $display("FAIL prio_ready got mr %b ar %b expected 1 0", mem_ready, alu_ready);
        end
        @(negedge clk);
        mem_valid = 0;
        #1;
        checks++;
        if (alu_ready !== 1'b1) begin
            errors++; $display("FAIL prio_alu_ready got %b expected 1", alu_ready);
        end
        @(negedge clk);
        alu_valid = 0;
        checks++;
        if ({write_en, write_reg, write_value} !== {1'b1, 2'd1, 8'h11}) begin
            errors++; $display("FAIL prio_first got we %b reg %0d val %h expected 1 1 11", write_en, write_reg, write_value);
        end
        @(negedge clk);
        checks++;
        if ({write_en, write_reg, write_value} !== {1'b1, 2'd3, 8'h22}) begin
            errors++; $display("FAIL prio_second got we %b reg %0d val %h expected 1 3 22", write_en, write_reg, write_value);
        end
        wait_idle("prio");
    endtask

    // The write port drains one entry per edge, so a single source held valid
    // keeps the FIFO at one entry and ready never drops.
    task automatic test_held_valid();
        for (int i = 0; i < 6; i++) begin
            alu_valid = 1; alu_reg = 2'(i); alu_value = 8'(8'hA0 + i);
            #1;
            checks++;
            if (alu_ready !== 1'b1) begin
                errors++; $display("FAIL held_ready_%0d got %b expected 1", i, alu_ready);
            end
            @(negedge clk);
        end
        alu_valid = 0;
        wait_idle("held");
    endtask

    task automatic test_same_reg();
        for (int i = 1; i <= 3; i++) begin
            alu_valid = 1; alu_reg = 0; alu_value = 8'(i);
            @(negedge clk);
            checks++;
            if (busy_mask[0] !== 1'b1) begin
                errors++; $display("FAIL samereg_busy_%0d got %b expected 1", i, busy_mask[0]);
            end
        end
        alu_valid = 0;
        @(negedge clk);
        checks++;
        if (busy_mask[0] !== 1'b1) begin
            errors++; $display("FAIL samereg_busy_last got %b expected 1", busy_mask[0]);
        end
        @(negedge clk);
        checks++;
        if (busy_mask[0] !== 1'b0 || regfile[0] !== 8'h03) begin
            errors++; $display("FAIL samereg_final got busy %b reg0 %h expected 0 03", busy_mask[0], regfile[0]);
        end
        wait_idle("samereg");
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            mem_valid = 1; mem_reg = 2'(i + 1); mem_value = 8'(8'hC0 + i);
            @(negedge clk);
        end
        checks++;
        if (write_en !== 1'b1) begin
            errors++; $display("FAIL midreset_pre got we %b expected 1", write_en);
        end
        reset = 1; mem_valid = 1; mem_reg = 3; mem_value = 8'hEE;
        @(negedge clk);
        mem_valid = 0;
        checks++;
        if (write_en !== 1'b0 || busy_mask !== 4'b0000 || idle !== 1'b1) begin
            errors++; $display("FAIL midreset_post got we %b busy %b idle %b expected 0 0000 1", write_en, busy_mask, idle);
        end
        reset = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (write_en !== 1'b0) begin
                errors++; $display("FAIL midreset_quiet_%0d got we %b expected 0", i, write_en);
            end
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 2 * DEPTH + 1; i++) begin
            mem_valid = 1; mem_reg = 2'(i % 4); mem_value = 8'(8'h30 + 7 * i);
            #1;
            checks++;
            if (mem_ready !== 1'b1) begin
                errors++; $display("FAIL wrap_ready_%0d got %b expected 1", i, mem_ready);
            end
            @(negedge clk);
        end
        mem_valid = 0;
        wait_idle("wrap");
    endtask

    initial begin
        idle_inputs();
        reset = 1;
        foreach (regfile[i]) regfile[i] = 8'h00;
        @(negedge clk);
        test_reset();
        test_single_latency();
        test_priority();
        test_held_valid();
        test_same_reg();
        test_reset_mid();
        test_wrap();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
